bcd_countdown: RTL

//   Loadable multi-digit BCD down-counter: the count-down counterpart of the decade up-counter.

---
 rtl/bcd_pkg.sv | 18 +
 rtl/bcd_down_digit.sv | 37 +++
 rtl/bcd_countdown.sv | 125 ++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD countdown timer: digit width, decade limit, FSM encodings.
package bcd_pkg;

  localparam int unsigned BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Force any non-decimal nibble down to 9 so the counter never holds an illegal digit.
  function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] n);
    return (n > BCD_MAX) ? BCD_MAX : n;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One decade of the BCD down-counter: loadable, decrements on enable, wraps 0 -> 9 with borrow.
module bcd_down_digit
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [BCD_W-1:0] value,
  input  logic             enable,
  output logic [BCD_W-1:0] digit,
  output logic             borrow_out
);

  logic [BCD_W-1:0] digit_q;
  logic [BCD_W-1:0] digit_d;

  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = bcd_clamp(value);
    end else if (enable) begin
      digit_d = (digit_q == '0) ? BCD_MAX : digit_q - BCD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit      = digit_q;
  assign borrow_out = enable && (digit_q == '0);

endmodule

// File: rtl/bcd_countdown.sv
// Loadable multi-decade BCD countdown timer with expiry flag; define COUNTDOWN_ABORT_EN
// to add an abort input that drops RUN back to IDLE while holding the count.
module bcd_countdown
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [BCD_W*DIGITS-1:0] load_value,
  input  logic                    start,
  input  logic                    tick,
`ifdef COUNTDOWN_ABORT_EN
  input  logic                    abort,
`endif
  output logic [BCD_W*DIGITS-1:0] count,
  output logic                    running,
  output logic                    done,
  output logic                    expired
);

  localparam int unsigned CW = BCD_W * DIGITS;

  state_e          state_q, state_d;
  logic            running_q, running_d;
  logic            done_q, done_d;
  logic            expired_q, expired_d;

  logic [CW-1:0]   count_w;
  logic            abort_c;
  logic            is_zero_c;
  logic            is_one_c;
  logic            count_en_c;
  logic [DIGITS-1:0] enable_w;
  logic [DIGITS-1:0] borrow_w;
  logic            borrow_unused;

`ifdef COUNTDOWN_ABORT_EN
  assign abort_c = abort;
`else
  assign abort_c = 1'b0;
`endif

  // Zero/one detectors; BCD 0..01 coincides with binary 1.
  assign is_zero_c = (count_w == '0);
  assign is_one_c  = (count_w == CW'(1));

  // Decrement only on a tick in RUN that is not overridden by load or abort.
  assign count_en_c = tick && (state_q == ST_RUN) && !load && !abort_c && !is_zero_c;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    if (i == 0) begin : g_lsd
      assign enable_w[i] = count_en_c;
    end else begin : g_upper
      assign enable_w[i] = borrow_w[i-1];
    end

    bcd_down_digit u_digit (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .value      (load_value[BCD_W*i +: BCD_W]),
      .enable     (enable_w[i]),
      .digit      (count_w[BCD_W*i +: BCD_W]),
      .borrow_out (borrow_w[i])
    );
  end

  // A borrow out of the top decade cannot occur because a zero count never decrements.
  assign borrow_unused = borrow_w[DIGITS-1];

  always_comb begin
    state_d   = state_q;
    expired_d = 1'b0;
    if (load) begin
      state_d = ST_IDLE;
    end else if (abort_c && (state_q == ST_RUN)) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (is_zero_c) begin
              state_d   = ST_DONE;
              expired_d = 1'b1;
            end else begin
              state_d = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (tick && is_one_c) begin
            state_d   = ST_DONE;
            expired_d = 1'b1;
          end
        end
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
    running_d = (state_d == ST_RUN);
    done_d    = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= running_d;
      done_q    <= done_d;
      expired_q <= expired_d;
    end
  end

  assign count   = count_w;
  assign running = running_q;
  assign done    = done_q;
  assign expired = expired_q;

endmodule
